// File: rtl/serial_and_or_reducer_if.sv
// Operand/result handshake bundle for serial_and_or_reducer.
// The master drives operands and consumes results; the slave is the reducer.
interface serial_and_or_reducer_if #(
    parameter int width = 8
);
    localparam int IW = ($clog2(width) > 1) ? $clog2(width) : 1;

    logic [width-1:0] a;
    logic             in_valid;
    logic             in_ready;
    logic             y;
    logic             hit;
    logic [IW-1:0]    idx;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, in_valid, out_ready,
        input  in_ready, y, hit, idx, out_valid
    );

    modport slave (
        input  a, in_valid, out_ready,
        output in_ready, y, hit, idx, out_valid
    );
endinterface

// File: rtl/serial_and_or_reducer.sv
// Bit-serial AND/OR reducer reporting the first deciding bit index.
// Define SERIAL_AND_OR_REDUCER_EARLY_TERM_EN to stop scanning at the first deciding bit.
module serial_and_or_reducer #(
    parameter int width = 8,
    parameter int sel   = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_and_or_reducer_if.slave bus
);
    localparam int IW = ($clog2(width) > 1) ? $clog2(width) : 1;
    localparam logic IS_AND = (sel == 1);
    localparam logic [IW-1:0] LAST = IW'(width - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [width-1:0] sh_q;
    logic [IW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic             acc_q;
    logic             hit_q;
    logic             bit_k;
    logic             dec;
    logic             last;

    assign bit_k = sh_q[0];
    assign dec   = IS_AND ? ~bit_k : bit_k;

`ifdef SERIAL_AND_OR_REDUCER_EARLY_TERM_EN
    assign last = (cnt_q == LAST) || dec;
`else
    assign last = (cnt_q == LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // idx preloads to the no-hit answer so only a hit needs to overwrite it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            acc_q <= 1'b0;
            hit_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh_q  <= bus.a;
                        cnt_q <= '0;
                        idx_q <= LAST;
                        acc_q <= IS_AND;
                        hit_q <= 1'b0;
                    end
                end
                SCAN: begin
                    sh_q  <= sh_q >> 1;
                    acc_q <= IS_AND ? (acc_q & bit_k) : (acc_q | bit_k);
                    if (!last) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (dec && !hit_q) begin
                        hit_q <= 1'b1;
                        idx_q <= cnt_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.y   = acc_q;
    assign bus.hit = hit_q;
    assign bus.idx = idx_q;
endmodule

// File: tb/tb_serial_and_or_reducer.sv
// Scoreboard bench for serial_and_or_reducer: AND and OR instances, width 8.
// Expected results are hand-computed; latencies depend on the early-term build.
module tb_serial_and_or_reducer;
`ifdef SERIAL_AND_OR_REDUCER_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    typedef struct {
        logic       y;
        logic       hit;
        logic [2:0] idx;
        int         acc;
        int         lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    exp_t qa[$];
    exp_t qo[$];
    exp_t ea;
    exp_t eo;
    bit   a_pv;
    bit   o_pv;

    serial_and_or_reducer_if #(.width(8)) ai ();
    serial_and_or_reducer_if #(.width(8)) oi ();

    serial_and_or_reducer #(.width(8), .sel(1)) u_and (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ai.slave)
    );

    serial_and_or_reducer #(.width(8), .sel(0)) u_or (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (oi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            a_pv = 1'b0;
        end else begin
            if (ai.out_valid && !a_pv) begin
                if (qa.size() == 0) begin
                    chk("and_unexpected_result", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    chk("and_y", int'(ai.y), int'(ea.y));
                    chk("and_hit", int'(ai.hit), int'(ea.hit));
                    chk("and_idx", int'(ai.idx), int'(ea.idx));
                    chk("and_latency", cyc - ea.acc, ea.lat);
                end
            end else if (ai.out_valid) begin
                chk("and_hold_y", int'(ai.y), int'(ea.y));
                chk("and_hold_hit", int'(ai.hit), int'(ea.hit));
                chk("and_hold_idx", int'(ai.idx), int'(ea.idx));
                chk("and_hold_in_ready", int'(ai.in_ready), 0);
            end
            a_pv = ai.out_valid;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            o_pv = 1'b0;
        end else begin
            if (oi.out_valid && !o_pv) begin
                if (qo.size() == 0) begin
                    chk("or_unexpected_result", 1, 0);
                end else begin
                    eo = qo.pop_front();
                    chk("or_y", int'(oi.y), int'(eo.y));
                    chk("or_hit", int'(oi.hit), int'(eo.hit));
                    chk("or_idx", int'(oi.idx), int'(eo.idx));
                    chk("or_latency", cyc - eo.acc, eo.lat);
                end
            end
            o_pv = oi.out_valid;
        end
    end

    task automatic wait_ready_and();
        int n = 0;
        while (!ai.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("and_in_ready_timeout", 0, 1);
    endtask

    task automatic wait_ready_or();
        int n = 0;
        while (!oi.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("or_in_ready_timeout", 0, 1);
    endtask

    // toggle=1 keeps wiggling in_valid with alt during the scan
    task automatic send_and(input logic [7:0] v, input logic [7:0] alt,
                            input bit toggle, input logic y,
                            input logic h, input logic [2:0] ix,
                            input int lat, input bit push);
        exp_t e;
        wait_ready_and();
        ai.a        = v;
        ai.in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.y   = y;
        e.hit = h;
        e.idx = ix;
        e.acc = cyc;
        e.lat = lat;
        if (push) qa.push_back(e);
        ai.in_valid = 1'b0;
        ai.a        = alt;
        if (toggle) begin
            for (int i = 0; i < 6; i++) begin
                ai.in_valid = ~ai.in_valid;
                ai.a        = ~ai.a;
                @(posedge clk);
                #1;
            end
            ai.in_valid = 1'b0;
        end
    endtask

    task automatic send_or(input logic [7:0] v, input logic y,
                           input logic h, input logic [2:0] ix,
                           input int lat);
        exp_t e;
        wait_ready_or();
        oi.a        = v;
        oi.in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.y   = y;
        e.hit = h;
        e.idx = ix;
        e.acc = cyc;
        e.lat = lat;
        qo.push_back(e);
        oi.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qo.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int n;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        ai.a         = '0;
        ai.in_valid  = 1'b0;
        ai.out_ready = 1'b1;
        oi.a         = '0;
        oi.in_valid  = 1'b0;
        oi.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", int'(ai.out_valid), 0);
        chk("rst_y", int'(ai.y), 0);
        chk("rst_hit", int'(ai.hit), 0);
        chk("rst_idx", int'(ai.idx), 0);
        chk("rst_or_y", int'(oi.y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(ai.in_ready), 1);

        // AND vectors
        send_and(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7, 8, 1'b1);
        drain();
        send_and(8'hFB, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, ET ? 3 : 8, 1'b1);
        drain();
        send_and(8'hFE, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, ET ? 1 : 8, 1'b1);
        drain();
        send_and(8'hEF, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, ET ? 5 : 8, 1'b1);
        drain();
        send_and(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 8, 1'b1);
        drain();

        // backpressure: hold out_ready low five cycles in DONE
        ai.out_ready = 1'b0;
        send_and(8'hFB, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, ET ? 3 : 8, 1'b1);
        n = 0;
        while (!ai.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("bp_out_valid_timeout", 0, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_still_valid", int'(ai.out_valid), 1);
        ai.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released_idle", int'(ai.in_ready), 1);
        chk("bp_released_valid", int'(ai.out_valid), 0);

        // reset mid-scan discards the operand
        send_and(8'hFB, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(ai.out_valid), 0);
        chk("mid_rst_y", int'(ai.y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready", int'(ai.in_ready), 1);
        send_and(8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8, 1'b1);
        drain();

        // OR vectors
        send_or(8'h00, 1'b0, 1'b0, 3'd7, 8);
        drain();
        send_or(8'hA0, 1'b1, 1'b1, 3'd5, ET ? 6 : 8);
        drain();
        send_or(8'h80, 1'b1, 1'b1, 3'd7, 8);
        drain();
        send_or(8'h01, 1'b1, 1'b1, 3'd0, ET ? 1 : 8);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("and_queue_empty", qa.size(), 0);
        chk("or_queue_empty", qo.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_and_or_reducer.md
SERIAL_AND_OR_REDUCER -- requirements
Module: serial_and_or_reducer

Interface
REQ-001 The module SHALL have parameter width, default 8, giving the operand bit count; legal values are >= 2.
REQ-002 The module SHALL have parameter sel, default 1, selecting the operation: 1 = AND reduction, any other value = OR reduction.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port a, input, width bits: operand, sampled only on acceptance.
REQ-006 The module SHALL have port in_valid, input, 1 bit: operand a is valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the block can accept an operand.
REQ-008 The module SHALL have port y, output, 1 bit: the reduction result.
REQ-009 The module SHALL have port hit, output, 1 bit: a deciding bit was found (a 0 for AND, a 1 for OR).
REQ-010 The module SHALL have port idx, output, IW = max(1, ceil(log2(width))) bits: index of the first deciding bit, or width-1 if hit=0.
REQ-011 The module SHALL have port out_valid, output, 1 bit: y, hit and idx are valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-013 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-014 In IDLE: in_ready SHALL be 1, out_valid 0, and the FSM SHALL move to SCAN on the first clock edge with in_valid=1; a is captured into an internal shift register and the bit counter is cleared to 0.
REQ-015 In SCAN: the FSM SHALL examine one bit per cycle, in order a[0], a[1], … a[width-1]; in_ready SHALL be 0; in_valid SHALL be ignored.
REQ-016 The accumulator SHALL start at the identity value (1 for AND, 0 for OR) and SHALL be updated as acc & a[k] (AND) or acc | a[k] (OR).
REQ-017 On the first deciding bit k, the block SHALL latch idx=k and hit=1; later deciding bits SHALL NOT change idx.
REQ-018 After bit width-1 is examined, the FSM SHALL enter DONE; at that point y equals the full AND/OR reduction of the captured a.
REQ-019 If no deciding bit occurs, the block SHALL set hit=0 and idx=width-1.
REQ-020 In DONE: out_valid SHALL be 1, and y, hit and idx SHALL stay stable until an edge with out_ready=1; the FSM then returns to IDLE.
REQ-021 A new operand SHALL NOT be accepted in the same cycle a result is consumed; back-to-back throughput is one operand per (latency + 2) cycles.
REQ-022 Latency from the acceptance edge to out_valid rising SHALL be width cycles (without early termination).
REQ-023 The bit counter SHALL be IW bits wide and SHALL NOT wrap within an operation.
REQ-024 out_ready held at 1 before DONE SHALL have no effect.

Reset
REQ-025 When rst_n=0, the FSM SHALL go to IDLE immediately, independent of clk.
REQ-026 During reset, the outputs SHALL be: in_ready=1 after release, out_valid=0, y=0, hit=0, idx=0; the accumulator, counter and shift register SHALL be cleared.
REQ-027 Reset asserted during SCAN or DONE SHALL discard the operation; no result is emitted for it.

Configuration
REQ-028 The macro SERIAL_AND_OR_REDUCER_EARLY_TERM_EN SHALL control early termination.
REQ-029 With the macro defined: the FSM SHALL leave SCAN after the first deciding bit k, and out_valid SHALL rise k+1 cycles after acceptance; y SHALL be 0 for AND or 1 for OR, and remaining bits SHALL NOT be examined.
REQ-030 With the macro defined and no deciding bit present, latency SHALL remain width cycles.
REQ-031 Without the macro, latency SHALL always be width cycles; y, hit and idx SHALL be identical to the early-termination build for every operand.

Verification
REQ-032 AND, width=8: a=8'hFF -> y=1, hit=0, idx=7, out_valid rises 8 cycles after acceptance.
REQ-033 AND, width=8: a=8'hFB -> y=0, hit=1, idx=2; latency is 3 cycles with the macro and 8 cycles without it.
REQ-034 OR, width=8: a=8'h00 -> y=0, hit=0, idx=7; a=8'hA0 -> y=1, hit=1, idx=5.
REQ-035 Backpressure: out_ready held at 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; accepted on the first out_ready=1 edge, then IDLE.
REQ-036 Reset mid-SCAN: rst_n pulsed low at cycle 3 -> out_valid=0 and y=0 immediately; in_ready=1 after release; the next operand a=8'h7F (AND) -> y=0, idx=7.
REQ-037 in_valid toggling during SCAN with a different a -> no effect on the result of the operand in progress.
